pll_phase_ctrl: RTL and testbench

//  Sequencer beside the ECP5 EHXPLLL of PLL_DSP: drives dynamic phase-shift pins
//  (PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG), filters LOCK, auto-resets PLL on lock timeout.

---
 rtl/pll_phase_ctrl_if.sv | 44 ++++
 rtl/pll_phase_ctrl.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_phase_ctrl_if.sv
// -----------------------------------------------------------------------------
// pll_phase_ctrl_if
//   Host-side bus of the PLL phase sequencer. It carries the phase-step request
//   handshake, the completion and rejection pulses, lock status, and the
//   read-back of the tracked per-output phase positions.
//
//   Signals (driver shown as master -> slave unless noted)
//     req_valid  m->s  1      phase-step request
//     req_ready  s->m  1      request can be taken (IDLE with lock)
//     req_sel    m->s  2      output index to shift
//     req_dir    m->s  1      0 = delay (+1/step), 1 = advance (-1/step)
//     req_steps  m->s  8      number of fine steps, 0 = no-op
//     rd_sel     m->s  2      output whose position is shown on phase_pos
//     phase_pos  s->m  POS_W  current position of rd_sel output
//     done       s->m  1      1-cycle pulse, request finished
//     err        s->m  1      1-cycle pulse, request rejected or aborted
//     locked     s->m  1      filtered PLL lock
//     lock_lost  s->m  1      sticky, lock fell since last accepted request
// -----------------------------------------------------------------------------
interface pll_phase_ctrl_if #(
   parameter int POS_W = 3
);
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_sel;
   logic             req_dir;
   logic [7:0]       req_steps;
   logic [1:0]       rd_sel;
   logic [POS_W-1:0] phase_pos;
   logic             done;
   logic             err;
   logic             locked;
   logic             lock_lost;

   modport master (
      output req_valid, req_sel, req_dir, req_steps, rd_sel,
      input  req_ready, phase_pos, done, err, locked, lock_lost
   );

   modport slave (
      input  req_valid, req_sel, req_dir, req_steps, rd_sel,
      output req_ready, phase_pos, done, err, locked, lock_lost
   );
endinterface

// File: rtl/pll_phase_ctrl.sv
// -----------------------------------------------------------------------------
// pll_phase_ctrl
//   Sequencer beside an ECP5 EHXPLLL. It drives the dynamic phase-shift pins
//   (PHASESEL/PHASEDIR/PHASESTEP/PHASELOADREG), filters the PLL LOCK signal,
//   pulses the PLL reset when lock does not arrive in time, and keeps a
//   per-output fine-phase position (modulo STEPS_PER_VCO) for up to four
//   outputs so capture clocks can be trimmed at run time.
//
//   Ports
//     clk           in   1   system clock (PLL CLKI domain)
//     rst           in   1   synchronous, active-high reset
//     bus           slave    request / status bus, see pll_phase_ctrl_if
//     pll_lock      in   1   raw PLL LOCK, asynchronous
//     phasesel      out  2   PLL PHASESEL
//     phasedir      out  1   PLL PHASEDIR
//     phasestep     out  1   PLL PHASESTEP
//     phaseloadreg  out  1   PLL PHASELOADREG, held 0
//     pll_rst       out  1   PLL RST
//
//   Request latency: SETUP_CYC + N*(PULSE_CYC+HOLD_CYC) + 1 cycles to done.
// -----------------------------------------------------------------------------
module pll_phase_ctrl #(
   parameter int NUM_OUT       = 4,
   parameter int STEPS_PER_VCO = 8,
   parameter int SETUP_CYC     = 2,
   parameter int PULSE_CYC     = 4,
   parameter int HOLD_CYC      = 4,
   parameter int LOCK_FILT     = 16,
   parameter int LOCK_TIMEOUT  = 65535,
   parameter int RST_CYC       = 32
) (
   input  logic            clk,
   input  logic            rst,
   pll_phase_ctrl_if.slave bus,
   input  logic            pll_lock,
   output logic [1:0]      phasesel,
   output logic            phasedir,
   output logic            phasestep,
   output logic            phaseloadreg,
   output logic            pll_rst
);

   localparam int POS_W   = $clog2(STEPS_PER_VCO);
   localparam int LF_W    = $clog2(LOCK_FILT + 1);
   localparam int MAX_A   = (LOCK_TIMEOUT > RST_CYC) ? LOCK_TIMEOUT : RST_CYC;
   localparam int MAX_B   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
   localparam int MAX_C   = (MAX_B > HOLD_CYC) ? MAX_B : HOLD_CYC;
   localparam int CNT_MAX = (MAX_A > MAX_C) ? MAX_A : MAX_C;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [2:0]       NUM_OUT_L = 3'(NUM_OUT);
   localparam logic [POS_W-1:0] POS_LAST  = POS_W'(STEPS_PER_VCO - 1);

   typedef enum logic [2:0] {
      S_PLL_RESET,
      S_WAIT_LOCK,
      S_IDLE,
      S_SETUP,
      S_STEP_HI,
      S_HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // Latched request
   logic [1:0]        sel_q;
   logic              dir_q;
   logic [7:0]        remaining_q;

   // Phase position per output; only entries below NUM_OUT are ever written
   logic [POS_W-1:0]  pos_q [4];

   // Lock synchroniser and filter
   logic              lock_s1, lock_s2;
   logic [LF_W-1:0]   lock_cnt_q;
   logic              locked;
   logic              locked_q;
   logic              lock_lost_q;

   logic              done_q, err_q;

   // Decode strobes from the next-state logic
   logic              accept;
   logic              step_end;
   logic              done_d, err_d;
   logic              sel_ok;
   logic              abort;
   logic              in_seq;

   // One fine step of an output position, wrapping modulo STEPS_PER_VCO.
   function automatic logic [POS_W-1:0] wrap_step(input logic [POS_W-1:0] p,
                                                  input logic             adv);
      if (adv) return (p == '0) ? POS_LAST : p - POS_W'(1);
      else     return (p == POS_LAST) ? '0 : p + POS_W'(1);
   endfunction

   assign locked = (lock_cnt_q == LF_W'(LOCK_FILT));
   assign sel_ok = ({1'b0, bus.req_sel} < NUM_OUT_L);
   // Lock lost at any point since this request was accepted ends the sequence
   // after the step in flight; lock_lost covers a glitch that has recovered.
   assign abort  = !locked || lock_lost_q;
   assign in_seq = (state_q == S_SETUP) || (state_q == S_STEP_HI) || (state_q == S_HOLD);

   // ---------------------------------------------------------------------------
   // Next-state and strobe decode
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q + CNT_W'(1);
      accept   = 1'b0;
      step_end = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         S_PLL_RESET: begin
            if (cnt_q == CNT_W'(RST_CYC - 1)) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end
         end

         S_WAIT_LOCK: begin
            if (locked) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
               state_d = S_PLL_RESET;
               cnt_d   = '0;
            end
         end

         S_IDLE: begin
            cnt_d = '0;
            if (!locked) begin
               state_d = S_WAIT_LOCK;
            end else if (bus.req_valid) begin
               // Output index is validated before the step count.
               if (!sel_ok) begin
                  err_d = 1'b1;
               end else if (bus.req_steps == '0) begin
                  done_d = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_d = S_SETUP;
               end
            end
         end

         S_SETUP: begin
            if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
               cnt_d = '0;
               if (abort) begin
                  err_d   = 1'b1;
                  state_d = S_WAIT_LOCK;
               end else begin
                  state_d = S_STEP_HI;
               end
            end
         end

         S_STEP_HI: begin
            // A started pulse always runs to full width and its hold time.
            if (cnt_q == CNT_W'(PULSE_CYC - 1)) begin
               cnt_d    = '0;
               step_end = 1'b1;
               state_d  = S_HOLD;
            end
         end

         S_HOLD: begin
            if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
               cnt_d = '0;
               if (abort) begin
                  err_d   = 1'b1;
                  state_d = S_WAIT_LOCK;
               end else if (remaining_q == '0) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  // Further steps skip SETUP: SEL/DIR are already stable.
                  state_d = S_STEP_HI;
               end
            end
         end

         default: begin
            state_d = S_PLL_RESET;
            cnt_d   = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments, so every register samples the values
      // from before the edge regardless of statement order.
      if (rst) begin
         state_q <= S_PLL_RESET;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Lock synchroniser, filter and loss flag
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_s1     <= 1'b0;
         lock_s2     <= 1'b0;
         lock_cnt_q  <= '0;
         locked_q    <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         lock_s1  <= pll_lock;
         lock_s2  <= lock_s1;
         locked_q <= locked;
         // Any synced low cycle restarts the filter; count saturates at LOCK_FILT.
         if (!lock_s2) begin
            lock_cnt_q <= '0;
         end else if (!locked) begin
            lock_cnt_q <= lock_cnt_q + LF_W'(1);
         end
         // An accept needs locked=1, so it can never coincide with a fall.
         if (accept) begin
            lock_lost_q <= 1'b0;
         end else if (locked_q && !locked) begin
            lock_lost_q <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Request latch, position table, result pulses
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_q       <= '0;
         dir_q       <= 1'b0;
         remaining_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         // NOTE: the position table is plain flops and must read 0 after reset,
         // so it is cleared along with the rest of the state.
         for (int i = 0; i < 4; i++) begin
            pos_q[i] <= '0;
         end
      end else begin
         done_q <= done_d;
         err_q  <= err_d;
         if (accept) begin
            sel_q       <= bus.req_sel;
            dir_q       <= bus.req_dir;
            remaining_q <= bus.req_steps;
         end
         // The position moves when the step pulse ends, so an aborted
         // sequence still reports every step the PLL actually took.
         if (step_end) begin
            remaining_q  <= remaining_q - 8'd1;
            pos_q[sel_q] <= wrap_step(pos_q[sel_q], dir_q);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign phasestep    = (state_q == S_STEP_HI);
   assign phasesel     = in_seq ? sel_q : 2'b00;
   assign phasedir     = in_seq & dir_q;
   assign phaseloadreg = 1'b0;
   assign pll_rst      = (state_q == S_PLL_RESET);

   assign bus.req_ready = (state_q == S_IDLE) && locked;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.locked    = locked;
   assign bus.lock_lost = lock_lost_q;
   assign bus.phase_pos = ({1'b0, bus.rd_sel} < NUM_OUT_L) ? pos_q[bus.rd_sel] : '0;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pll_phase_ctrl
//   Directed bench for pll_phase_ctrl with NUM_OUT=2 and a short lock timeout.
//   Covers reset/lock bring-up, a step waveform, a table of requests (wraps,
//   rejects, no-ops, max step count), lock loss mid-sequence, lock timeout
//   retries and reset mid-sequence.
// -----------------------------------------------------------------------------
module tb_pll_phase_ctrl;

   localparam int TIMEOUT = 200;
   localparam int RSTC    = 32;

   logic       clk = 1'b0;
   logic       rst;
   logic       pll_lock;
   logic [1:0] phasesel;
   logic       phasedir;
   logic       phasestep;
   logic       phaseloadreg;
   logic       pll_rst;

   pll_phase_ctrl_if #(.POS_W(3)) bus ();

   pll_phase_ctrl #(
      .NUM_OUT      (2),
      .LOCK_TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .pll_lock     (pll_lock),
      .phasesel     (phasesel),
      .phasedir     (phasedir),
      .phasestep    (phasestep),
      .phaseloadreg (phaseloadreg),
      .pll_rst      (pll_rst)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic get_pos(input logic [1:0] s, output logic [2:0] p);
      bus.rd_sel = s;
      #1;
      p = bus.phase_pos;
   endtask

   typedef struct {
      logic [1:0] sel;
      logic       dir;
      logic [7:0] steps;
      logic       exp_err;
      int         exp_lat;
      int         exp_pulses;
      logic [2:0] exp_pos0;
      logic [2:0] exp_pos1;
   } vec_t;

   vec_t vecs [8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          n;
      int          lat;
      int          pulses;
      logic        prev;
      logic        got_done;
      logic        got_err;
      logic        ready_seen;
      logic [2:0]  p;
      logic [39:0] ps_seen;
      logic [39:0] ps_exp;

      // Positions entering the table: pos0=0, pos1=3.
      vecs[0] = '{2'd0, 1'b1, 8'd1,   1'b0, 11,   1,   3'd7, 3'd3}; // 0 -> 7 wrap
      vecs[1] = '{2'd0, 1'b0, 8'd9,   1'b0, 75,   9,   3'd0, 3'd3}; // 7+9 -> 0
      vecs[2] = '{2'd3, 1'b0, 8'd2,   1'b1, 1,    0,   3'd0, 3'd3}; // bad sel
      vecs[3] = '{2'd2, 1'b1, 8'd1,   1'b1, 1,    0,   3'd0, 3'd3}; // sel == NUM_OUT
      vecs[4] = '{2'd1, 1'b0, 8'd0,   1'b0, 1,    0,   3'd0, 3'd3}; // no-op
      vecs[5] = '{2'd3, 1'b0, 8'd0,   1'b1, 1,    0,   3'd0, 3'd3}; // sel before steps
      vecs[6] = '{2'd1, 1'b1, 8'd4,   1'b0, 35,   4,   3'd0, 3'd7}; // 3-4 -> 7
      vecs[7] = '{2'd1, 1'b0, 8'd255, 1'b0, 2043, 255, 3'd0, 3'd6}; // 7+255 -> 6

      rst           = 1'b1;
      pll_lock      = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_sel   = 2'd0;
      bus.req_dir   = 1'b0;
      bus.req_steps = 8'd0;
      bus.rd_sel    = 2'd0;
      repeat (3) tick();

      // ---- reset state ----
      check("rst_pll_rst",   pll_rst, 1);
      check("rst_phasestep", phasestep, 0);
      check("rst_phasesel",  phasesel, 0);
      check("rst_phasedir",  phasedir, 0);
      check("rst_loadreg",   phaseloadreg, 0);
      check("rst_locked",    bus.locked, 0);
      check("rst_lock_lost", bus.lock_lost, 0);
      check("rst_ready",     bus.req_ready, 0);
      check("rst_done_err",  {bus.done, bus.err}, 0);
      check("rst_pos",       bus.phase_pos, 0);

      // ---- PLL reset pulse width, then lock at cycle 40 ----
      rst = 1'b0;
      n = 0;
      while (pll_rst && n < 100) begin
         n++;
         tick();
      end
      check("pll_rst_width", n, RSTC);
      repeat (40 - RSTC) tick();
      pll_lock = 1'b1;
      repeat (17) tick();
      check("locked_early", bus.locked, 0);
      tick();
      check("locked_on_time", bus.locked, 1);
      check("ready_before_idle", bus.req_ready, 0);
      tick();
      check("ready_idle", bus.req_ready, 1);

      // ---- waveform: SEL=1 DIR=0 STEPS=3 ----
      bus.req_sel   = 2'd1;
      bus.req_dir   = 1'b0;
      bus.req_steps = 8'd3;
      bus.req_valid = 1'b1;
      ps_seen = '0;
      ps_exp  = '0;
      for (int t = 3; t < 27; t++) begin
         if (((t - 3) % 8) < 4) ps_exp[t] = 1'b1;
      end
      lat = 0;
      for (int t = 1; t <= 39 && lat == 0; t++) begin
         tick();
         if (t == 1) begin
            bus.req_valid = 1'b0;
            check("wave_phasesel", phasesel, 1);
            check("wave_ready_busy", bus.req_ready, 0);
         end
         ps_seen[t] = phasestep;
         if (bus.done) lat = t;
      end
      check("wave_latency", lat, 27);
      check("wave_phasestep", ps_seen, ps_exp);
      check("wave_phasesel_idle", phasesel, 0);
      get_pos(2'd1, p);
      check("wave_pos1", p, 3);
      get_pos(2'd0, p);
      check("wave_pos0", p, 0);
      tick();
      check("wave_done_pulse", bus.done, 0);

      // ---- request table ----
      for (int i = 0; i < 8; i++) begin
         bus.req_sel   = vecs[i].sel;
         bus.req_dir   = vecs[i].dir;
         bus.req_steps = vecs[i].steps;
         bus.req_valid = 1'b1;
         lat = 0; pulses = 0; prev = 1'b0; got_done = 1'b0; got_err = 1'b0;
         for (int t = 1; t <= 3000 && lat == 0; t++) begin
            tick();
            bus.req_valid = 1'b0;
            if (phasestep && !prev) pulses++;
            prev = phasestep;
            if (bus.done || bus.err) begin
               lat      = t;
               got_done = bus.done;
               got_err  = bus.err;
            end
         end
         check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
         check($sformatf("vec%0d_err", i),     got_err, vecs[i].exp_err);
         check($sformatf("vec%0d_done", i),    got_done, !vecs[i].exp_err);
         check($sformatf("vec%0d_pulses", i),  pulses, vecs[i].exp_pulses);
         get_pos(2'd0, p);
         check($sformatf("vec%0d_pos0", i),    p, vecs[i].exp_pos0);
         get_pos(2'd1, p);
         check($sformatf("vec%0d_pos1", i),    p, vecs[i].exp_pos1);
         tick();
      end
      check("table_lock_lost", bus.lock_lost, 0);
      get_pos(2'd2, p);
      check("rd_sel2_zero", p, 0);
      get_pos(2'd3, p);
      check("rd_sel3_zero", p, 0);

      // ---- lock drop during step 2 of 5 ----
      bus.req_sel   = 2'd0;
      bus.req_dir   = 1'b0;
      bus.req_steps = 8'd5;
      bus.req_valid = 1'b1;
      lat = 0; pulses = 0; prev = 1'b0; got_done = 1'b0; got_err = 1'b0;
      for (int t = 1; t <= 100 && lat == 0; t++) begin
         tick();
         bus.req_valid = 1'b0;
         if (t == 11) pll_lock = 1'b0;
         if (phasestep && !prev) pulses++;
         prev = phasestep;
         if (bus.done || bus.err) begin
            lat      = t;
            got_done = bus.done;
            got_err  = bus.err;
         end
      end
      check("drop_latency", lat, 19);
      check("drop_err", got_err, 1);
      check("drop_done", got_done, 0);
      check("drop_pulses", pulses, 2);
      get_pos(2'd0, p);
      check("drop_pos0", p, 2);
      check("drop_lock_lost", bus.lock_lost, 1);
      check("drop_locked", bus.locked, 0);
      check("drop_ready", bus.req_ready, 0);
      check("drop_pll_rst", pll_rst, 0);

      // ---- lock timeout: PLL reset retried every TIMEOUT+RSTC cycles ----
      ready_seen = 1'b0;
      n = 0;
      while (!pll_rst && n < 1000) begin
         tick();
         n++;
         ready_seen |= bus.req_ready;
      end
      check("timeout_first", n, TIMEOUT);
      n = 0;
      while (pll_rst && n < 100) begin
         n++;
         tick();
         ready_seen |= bus.req_ready;
      end
      check("timeout_rst_width", n, RSTC);
      n = 0;
      while (!pll_rst && n < 1000) begin
         tick();
         n++;
         ready_seen |= bus.req_ready;
      end
      check("timeout_period", n + RSTC, TIMEOUT + RSTC);
      check("timeout_ready_low", ready_seen, 0);

      // ---- relock; lock_lost sticky until an accepted request ----
      pll_lock = 1'b1;
      n = 0;
      while (!bus.req_ready && n < 400) begin
         tick();
         n++;
      end
      check("relock_ready", bus.req_ready, 1);
      check("relock_lost_sticky", bus.lock_lost, 1);
      bus.req_sel   = 2'd1;
      bus.req_dir   = 1'b0;
      bus.req_steps = 8'd1;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      check("accept_clears_lost", bus.lock_lost, 0);
      lat = 0;
      for (int t = 2; t <= 50 && lat == 0; t++) begin
         tick();
         if (bus.done) lat = t;
      end
      check("relock_latency", lat, 11);
      get_pos(2'd1, p);
      check("relock_pos1", p, 7);
      tick();

      // ---- reset mid-sequence ----
      bus.req_sel   = 2'd0;
      bus.req_dir   = 1'b1;
      bus.req_steps = 8'd2;
      bus.req_valid = 1'b1;
      tick();
      bus.req_valid = 1'b0;
      repeat (3) tick();
      check("midrst_step_high", phasestep, 1);
      rst = 1'b1;
      tick();
      check("midrst_phasestep", phasestep, 0);
      check("midrst_phasesel", phasesel, 0);
      check("midrst_pll_rst", pll_rst, 1);
      check("midrst_locked", bus.locked, 0);
      check("midrst_ready", bus.req_ready, 0);
      get_pos(2'd0, p);
      check("midrst_pos0", p, 0);
      get_pos(2'd1, p);
      check("midrst_pos1", p, 0);
      rst = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
